div_issue_queue: RTL

//  Upstream feeder for the GF(p) divider (p = 2^31-1). Accepts tagged divide requests
//  (a/b) on a valid/ready port, buffers them in a small FIFO, canonicalises operands,

---
 rtl/alu_pkg.sv | 33 +++
 rtl/div_issue_queue_fifo.sv | 69 ++++++
 rtl/div_issue_queue.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Shared constants, error codes and issue-FSM state encoding for
//          the GF(2^31-1) divider feeder.
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Field modulus p = 2^31-1; an operand equal to p is the residue 0.
    localparam logic [30:0] P_MOD    = 31'h7FFF_FFFF;

    // Response error codes
    localparam logic [1:0]  ERR_OK   = 2'b00;
    localparam logic [1:0]  ERR_DIV0 = 2'b01;
    localparam logic [1:0]  ERR_TMO  = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } issue_state_t;

    // Fold the non-canonical encoding of zero (p itself) onto 0.
    function automatic logic [30:0] canon(input logic [30:0] x);
        return (x == P_MOD) ? 31'd0 : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_issue_queue_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO, power-of-two depth, registered pointers and an
//          occupancy counter. Push into a full FIFO is ignored, so a
//          simultaneous push/pop when full only pops.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full_cnt = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_full_cnt);
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rd_ptr];

    // Storage array: written on accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; counter tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_issue_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : div_issue_queue
// Brief  : Request queue and issue sequencer in front of the GF(2^31-1)
//          divider. Buffers tagged a/b requests, traps division by zero,
//          runs the divider's opselect/rdy handshake one request at a time
//          with a timeout, and returns results in request order.
// Rev    : 1.0  initial release
// ============================================================================
module div_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int TMO   = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [30:0]      req_a,
    input  logic [30:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_opselect,
    output logic [30:0]      div_a,
    output logic [30:0]      div_b,
    input  logic [30:0]      div_q,
    input  logic             div_rdy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [30:0]      rsp_q,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_err
);

    localparam int                c_ent_w    = 62 + TAG_W;
    localparam int                c_cnt_w    = $clog2(TMO + 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TMO - 1);

    issue_state_t        r_state;
    issue_state_t        w_next;

    logic [c_ent_w-1:0]  w_fifo_din;
    logic [c_ent_w-1:0]  w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    logic [30:0]         w_head_a;
    logic [30:0]         w_head_b;
    logic [TAG_W-1:0]    w_head_tag;

    logic                w_load;
    logic                w_fin;
    logic [30:0]         w_fin_q;
    logic [1:0]          w_fin_err;

    logic                r_wb_seen;
    logic [c_cnt_w-1:0]  r_tmo_cnt;
    logic [30:0]         r_div_a;
    logic [30:0]         r_div_b;
    logic [30:0]         r_rsp_q;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic [1:0]          r_rsp_err;

    // Queue entry layout: {a, b, tag}; canonicalisation happens on dequeue.
    assign w_fifo_din = {req_a, req_b, req_tag};
    assign w_head_a   = canon(w_head[TAG_W+61 -: 31]);
    assign w_head_b   = canon(w_head[TAG_W+30 -: 31]);
    assign w_head_tag = w_head[TAG_W-1:0];

    assign req_ready  = ~rst & ~w_full;
    assign w_push     = req_valid & req_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ent_w)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Issue FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, dequeue, divider start and completion decode.
    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_fin        = 1'b0;
        w_fin_q      = 31'd0;
        w_fin_err    = ERR_OK;
        div_opselect = 1'b0;
        case (r_state)
            IDLE: begin
                // rsp slot is always free here: RESP only exits on handshake.
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_b == 31'd0) begin
                        w_fin     = 1'b1;
                        w_fin_err = ERR_DIV0;
                        w_next    = RESP;
                    end else begin
                        w_load = 1'b1;
                        w_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (div_rdy) begin
                    div_opselect = 1'b1;
                    w_next       = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // The divider drops rdy one cycle after start; if it never
                // does within two cycles, treat the busy phase as seen.
                if (!div_rdy || r_wb_seen) begin
                    w_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (div_rdy) begin
                    w_fin   = 1'b1;
                    w_fin_q = div_q;
                    w_next  = RESP;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_fin     = 1'b1;
                    w_fin_err = ERR_TMO;
                    w_next    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Busy-phase marker and WAIT_DONE cycle counter, cleared outside their states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_seen <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_wb_seen <= (r_state == WAIT_BUSY);
            r_tmo_cnt <= (r_state == WAIT_DONE) ? r_tmo_cnt + 1'b1 : '0;
        end
    end

    // Divider operands (only change when leaving IDLE) and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_a   <= 31'd0;
            r_div_b   <= 31'd0;
            r_rsp_q   <= 31'd0;
            r_rsp_tag <= '0;
            r_rsp_err <= ERR_OK;
        end else begin
            if (w_load) begin
                r_div_a <= w_head_a;
                r_div_b <= w_head_b;
            end
            if (w_pop) begin
                r_rsp_tag <= w_head_tag;
            end
            if (w_fin) begin
                r_rsp_q   <= w_fin_q;
                r_rsp_err <= w_fin_err;
            end
        end
    end

    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign rsp_valid = (r_state == RESP);
    assign rsp_q     = r_rsp_q;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
